// File: rtl/xlr8_text_fetch.sv
// Purpose: 80x30 text-mode renderer (8x16 glyphs, CGA palette) over a 640x480 visible area.
// Latency: rgb/de_out are registered one pixel clock after cx/cy/de_in; RAM and font fetches run ahead.
// Backpressure: none; free-running pixel stream. Optional macro TEXT_BLINK_EN adds attr[7] blink.
module xlr8_text_fetch #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic        clk_pixel,
  input  logic        rstn,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic        de_in,
  input  logic [7:0]  row_offset,
  output logic [12:0] ram_address,
  output logic        ram_char_re,
  output logic        ram_attr_re,
  input  logic [7:0]  ram_char_data,
  input  logic [7:0]  ram_attr_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [23:0] rgb,
  output logic        de_out
);

  localparam logic [9:0] LP_H_VIS     = 10'd640;
  localparam logic [9:0] LP_V_VIS     = 10'd480;
  localparam logic [9:0] LP_MID_LAST  = 10'd632;
  localparam logic [9:0] LP_EOL_FETCH = 10'(H_TOTAL - 4);
  localparam logic [9:0] LP_H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] LP_V_LAST    = 10'(V_TOTAL - 1);

  localparam logic [23:0] LP_CGA [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  logic        w_mid_fetch;
  logic        w_eol_fetch;
  logic        w_fetch;
  logic        w_load;
  logic        w_bit;
  logic        w_vis;
  logic        w_unused;
  logic [9:0]  w_tline;
  logic [6:0]  w_tcol;
  logic [4:0]  w_ro;
  logic [5:0]  w_sum;
  logic [4:0]  w_phys;
  logic [12:0] w_addr;
  logic [7:0]  w_attr;
  logic [3:0]  w_fg_idx;
  logic [3:0]  w_bg_idx;
  logic [3:0]  w_cidx;
  logic [23:0] w_rgb;

  logic        r_re;
  logic [12:0] r_addr;
  logic [3:0]  r_frow;
  logic        r_dvld;
  logic        r_fvld;
  logic [11:0] r_font_addr;
  logic [7:0]  r_attr_pend;
  logic [7:0]  r_shift;
  logic [7:0]  r_attr;
  logic [23:0] r_rgb;
  logic        r_de;

  // Fetch slots: mid-line slots fetch the next column, the end-of-line slot fetches column 0 of the next line
  assign w_mid_fetch = (cx[2:0] == 3'd4) && (cx < LP_MID_LAST);
  assign w_eol_fetch = (cx == LP_EOL_FETCH);
  assign w_fetch     = (w_mid_fetch || w_eol_fetch) && (w_tline < LP_V_VIS);

  // Target line/column of the fetch slot in this cycle
  always_comb begin
    w_tline = cy;
    w_tcol  = 7'd0;
    if (w_eol_fetch) begin
      w_tline = (cy == LP_V_LAST) ? 10'd0 : cy + 10'd1;
    end else if (w_mid_fetch) begin
      w_tcol = cx[9:3] + 7'd1;
    end
  end

  // Scrolled physical text row; offsets 30/31 behave as 0, sum wraps at 30
  assign w_ro     = (row_offset[4:0] >= 5'd30) ? 5'd0 : row_offset[4:0];
  assign w_sum    = w_tline[9:4] + {1'b0, w_ro};
  assign w_phys   = (w_sum >= 6'd30) ? 5'(w_sum - 6'd30) : w_sum[4:0];
  assign w_addr   = {2'b00, w_phys, 6'd0} + {4'd0, w_phys, 4'd0} + {6'd0, w_tcol};
  assign w_unused = ^row_offset[7:5];

  // Issue the RAM read; row_offset is only sampled here so a change never splits a fetch
  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      r_re   <= 1'b0;
      r_addr <= 13'd0;
      r_frow <= 4'd0;
    end else begin
      r_re <= w_fetch;
      if (w_fetch) begin
        r_addr <= w_addr;
        r_frow <= w_tline[3:0];
      end
    end
  end

  // RAM data arrives the cycle after the enable; turn it into a font lookup and hold attr until load
  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      r_dvld      <= 1'b0;
      r_fvld      <= 1'b0;
      r_font_addr <= 12'd0;
      r_attr_pend <= 8'd0;
    end else begin
      r_dvld <= r_re;
      if (r_dvld) begin
        r_font_addr <= {ram_char_data, r_frow};
        r_attr_pend <= ram_attr_data;
        r_fvld      <= 1'b1;
      end else if (w_load) begin
        r_fvld <= 1'b0;
      end
    end
  end

  // First pixel of a column takes glyph bit 7 straight from the font; the rest come from the shifter.
  // A column with no completed fetch behind it renders as glyph 0 / attr 0.
  assign w_load = (cx[2:0] == 3'd0);
  always_comb begin
    w_bit  = r_shift[~cx[2:0]];
    w_attr = r_attr;
    if (w_load) begin
      w_bit  = r_fvld & font_data[7];
      w_attr = r_fvld ? r_attr_pend : 8'd0;
    end
  end

  // Load glyph row and attr into the pixel shifter at the first pixel of each column
  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      r_shift <= 8'd0;
      r_attr  <= 8'd0;
    end else if (w_load) begin
      r_shift <= r_fvld ? font_data : 8'd0;
      r_attr  <= r_fvld ? r_attr_pend : 8'd0;
    end
  end

`ifdef TEXT_BLINK_EN
  logic [5:0] r_frame;

  // Frame counter advances on the last pixel of the frame; bit 5 gives a 32-frame blink phase
  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      r_frame <= 6'd0;
    end else if ((cx == LP_H_LAST) && (cy == LP_V_LAST)) begin
      r_frame <= r_frame + 6'd1;
    end
  end

  // Colour select: 8 backgrounds, attr[7] hides the foreground during the blink-off phase
  always_comb begin
    w_fg_idx = w_attr[3:0];
    w_bg_idx = {1'b0, w_attr[6:4]};
    if (w_attr[7] && r_frame[5]) begin
      w_fg_idx = w_bg_idx;
    end
    w_cidx = w_bit ? w_fg_idx : w_bg_idx;
  end
`else
  // Colour select: 16 foregrounds and 16 backgrounds
  always_comb begin
    w_fg_idx = w_attr[3:0];
    w_bg_idx = w_attr[7:4];
    w_cidx   = w_bit ? w_fg_idx : w_bg_idx;
  end
`endif

  assign w_rgb = LP_CGA[w_cidx];
  assign w_vis = (cx < LP_H_VIS) && (cy < LP_V_VIS);

  // Output register: one-cycle latency, black outside the visible area
  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      r_rgb <= 24'd0;
      r_de  <= 1'b0;
    end else begin
      r_rgb <= w_vis ? w_rgb : 24'd0;
      r_de  <= de_in;
    end
  end

  assign ram_address = r_addr;
  assign ram_char_re = r_re;
  assign ram_attr_re = r_re;
  assign font_addr   = r_font_addr;
  assign rgb         = r_rgb;
  assign de_out      = r_de;

endmodule

// File: tb/tb_xlr8_text_fetch.sv
// Bench for xlr8_text_fetch: drives selected scan lines with a RAM/font model and
// compares every output against a per-pixel reference computed from screen contents.
// Honours TEXT_BLINK_EN in its reference colour rules.
module tb_xlr8_text_fetch;

  localparam int HT = 800;
  localparam int VT = 525;

  logic        clk_pixel = 1'b0;
  logic        rstn;
  logic [9:0]  cx, cy;
  logic        de_in;
  logic [7:0]  row_offset;
  logic [12:0] ram_address;
  logic        ram_char_re, ram_attr_re;
  logic [7:0]  ram_char_data, ram_attr_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [23:0] rgb;
  logic        de_out;

  xlr8_text_fetch #(.H_TOTAL(HT), .V_TOTAL(VT)) dut (
    .clk_pixel(clk_pixel), .rstn(rstn), .cx(cx), .cy(cy), .de_in(de_in),
    .row_offset(row_offset), .ram_address(ram_address),
    .ram_char_re(ram_char_re), .ram_attr_re(ram_attr_re),
    .ram_char_data(ram_char_data), .ram_attr_data(ram_attr_data),
    .font_addr(font_addr), .font_data(font_data), .rgb(rgb), .de_out(de_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  logic [7:0]  cmem [0:2399];
  logic [7:0]  amem [0:2399];
  logic [7:0]  fmem [0:4095];
  logic [23:0] obs  [0:799];

  // Synchronous RAM and font ROM; RAM returns junk when not enabled
  always @(posedge clk_pixel) begin
    ram_char_data <= ram_char_re ? cmem[ram_address] : 8'($urandom);
    ram_attr_data <= ram_attr_re ? amem[ram_address] : 8'($urandom);
    font_data     <= fmem[font_addr];
  end

  int ncmp = 0;
  int nfail = 0;
  int mframe = 0;
  int blank_line = -1;
  int blank_until = 0;
  int npulse = 0;
  logic [12:0] addr796;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h (cx=%0d cy=%0d)", tag, got, exp, cx, cy);
    end
  endtask

  function automatic logic [23:0] cga(input logic [3:0] i);
    case (i)
      4'd0:  return 24'h000000;  4'd1:  return 24'h0000AA;
      4'd2:  return 24'h00AA00;  4'd3:  return 24'h00AAAA;
      4'd4:  return 24'hAA0000;  4'd5:  return 24'hAA00AA;
      4'd6:  return 24'hAA5500;  4'd7:  return 24'hAAAAAA;
      4'd8:  return 24'h555555;  4'd9:  return 24'h5555FF;
      4'd10: return 24'h55FF55;  4'd11: return 24'h55FFFF;
      4'd12: return 24'hFF5555;  4'd13: return 24'hFF55FF;
      4'd14: return 24'hFFFF55;  default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic int phys_row(input int line, input int ro);
    int r;
    r = (ro >= 30) ? 0 : ro;
    return (line / 16 + r) % 30;
  endfunction

  // Colour of screen pixel (x,y) from the character/attr/font contents
  function automatic logic [23:0] exp_pix(input int x, input int y, input int ro);
    int a;
    logic [7:0] ch, at, g;
    logic [3:0] fg, bg;
    logic b;
    if (x >= 640 || y >= 480) return 24'h0;
    if (y == blank_line && x < blank_until) return 24'h0;
    a  = phys_row(y, ro) * 80 + x / 8;
    ch = cmem[a];
    at = amem[a];
    g  = fmem[{ch, 4'(y % 16)}];
    b  = g[7 - x % 8];
    fg = at[3:0];
`ifdef TEXT_BLINK_EN
    bg = {1'b0, at[6:4]};
    if (at[7] && mframe >= 32) fg = bg;
`else
    bg = at[7:4];
`endif
    return cga(b ? fg : bg);
  endfunction

  // Does pixel slot (x,y) launch a RAM read, and for which address
  function automatic bit fetch_of(input int x, input int y, input int ro, output int addr);
    int tl, tc;
    addr = 0;
    if (x == HT - 4) begin
      tl = (y == VT - 1) ? 0 : y + 1;
      tc = 0;
    end else if (x % 8 == 4 && x < 632) begin
      tl = y;
      tc = x / 8 + 1;
    end else begin
      return 1'b0;
    end
    if (tl >= 480) return 1'b0;
    addr = phys_row(tl, ro) * 80 + tc;
    return 1'b1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rgb"}, 32'(rgb), 32'd0);
    chk({tag, "_de"}, 32'(de_out), 32'd0);
    chk({tag, "_cre"}, 32'(ram_char_re), 32'd0);
    chk({tag, "_are"}, 32'(ram_attr_re), 32'd0);
    chk({tag, "_addr"}, 32'(ram_address), 32'd0);
    chk({tag, "_font"}, 32'(font_addr), 32'd0);
  endtask

  // One pixel clock: drive on the falling edge, check shortly after the rising edge
  task automatic step(input int x, input int y, input logic de, input bit mid_rst = 1'b0);
    logic [23:0] ep;
    bit fe;
    int fa;
    @(negedge clk_pixel);
    cx = 10'(x); cy = 10'(y); de_in = de;
    if (mid_rst) begin
      #2 rstn = 1'b0;
      mframe = 0;
      #1 chk_reset_outputs("rst_async");
    end
    ep = exp_pix(x, y, int'(row_offset));
    fe = fetch_of(x, y, int'(row_offset), fa);
    if (rstn && x == HT - 1 && y == VT - 1) mframe = (mframe + 1) % 64;
    @(posedge clk_pixel);
    #1;
    if (!rstn) begin
      chk_reset_outputs("rst_hold");
    end else begin
      chk("rgb", 32'(rgb), 32'(ep));
      chk("de_out", 32'(de_out), 32'(de));
      chk("char_re", 32'(ram_char_re), 32'(fe));
      chk("attr_re", 32'(ram_attr_re), 32'(fe));
      if (fe) chk("ram_addr", 32'(ram_address), 32'(fa));
      if (ram_char_re) npulse++;
      if (x == 796 && ram_char_re) addr796 = ram_address;
      obs[x] = rgb;
    end
  endtask

  // Drive the tail of the previous line (so column 0 gets fetched) then all of line L
  task automatic run_line(input int L, input int ro);
    int prev, nl, n;
    row_offset = 8'(ro);
    prev = (L == 0) ? VT - 1 : L - 1;
    nl = (L == VT - 1) ? 0 : L + 1;
    npulse = 0;
    addr796 = 13'h1FFF;
    for (int x = 792; x < HT; x++) step(x, prev, 1'b0);
    for (int x = 0; x < HT; x++) step(x, L, (x < 640 && L < 480));
    n = ((L < 480) ? 80 : 0) + ((nl < 480) ? 1 : 0);
    chk("pulses_per_line", 32'(npulse), 32'(n));
  endtask

  task automatic advance_to_frame(input int t);
    int k;
    k = ((t - 1 - mframe) % 64 + 64) % 64;
    for (int i = 0; i < k; i++) step(HT - 1, VT - 1, 1'b0);
  endtask

  initial begin
    int cf;
    for (int i = 0; i < 2400; i++) begin
      cmem[i] = 8'($urandom);
      amem[i] = 8'($urandom);
    end
    for (int i = 0; i < 4096; i++) fmem[i] = 8'($urandom);
    cx = 10'd0; cy = 10'd0; de_in = 1'b0; row_offset = 8'd0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    for (int i = 0; i < 4; i++) step($urandom_range(0, HT - 1), $urandom_range(0, VT - 1), 1'($urandom));
    @(negedge clk_pixel);
    rstn = 1'b1;

    // Character 'A' at cell 0, white on blue
    cmem[0] = 8'h41; amem[0] = 8'h1F; fmem[12'h410] = 8'h18;
    run_line(0, 0);
    for (int i = 0; i < 8; i++)
      chk("glyph_A_row0", 32'(obs[i]), (i == 3 || i == 4) ? 32'hFFFFFF : 32'h0000AA);

    // Fetch schedule and addressing across boundary lines
    run_line(15, 0);
    run_line(16, 0);
    chk("addr_l15_cx796", 32'(addr796), 32'd80);
    run_line(479, 0);
    run_line(480, 0);
    run_line(524, 0);

    // Scroll offset wrap and out-of-range offsets
    run_line(16, 29);
    chk("addr_ro29", 32'(addr796), 32'd0);
    run_line(16, 31);
    chk("addr_ro31", 32'(addr796), 32'd80);

    // Random lines and offsets
    for (int r = 0; r < 6; r++) run_line($urandom_range(0, 479), $urandom_range(0, 31));

    // Reset pulse in mid line 200
    row_offset = 8'd0;
    for (int x = 792; x < HT; x++) step(x, 199, 1'b0);
    for (int x = 0; x < 300; x++) step(x, 200, 1'b1);
    step(300, 200, 1'b1, 1'b1);
    step(301, 200, 1'b1);
    step(302, 200, 1'b1);
    rstn = 1'b1;
    cf = 303;
    while (cf % 8 != 4) cf++;
    blank_line = 200;
    blank_until = (cf / 8 + 1) * 8;
    for (int x = 303; x < HT; x++) step(x, 200, x < 640);
    blank_line = -1;
    for (int x = 0; x < HT; x++) step(x, 201, x < 640);

    // Blink attribute across the frame-counter phases, including the 63->0 wrap
    cmem[0] = 8'h41; amem[0] = 8'h87; fmem[12'h410] = 8'h18;
    for (int j = 0; j < 4; j++) begin
      int t;
      t = (j == 0) ? 31 : (j == 1) ? 32 : (j == 2) ? 63 : 0;
      advance_to_frame(t);
      run_line(0, 0);
`ifdef TEXT_BLINK_EN
      chk("blink_bg", 32'(obs[0]), 32'h000000);
      chk("blink_fg", 32'(obs[3]), (t >= 32) ? 32'h000000 : 32'hAAAAAA);
`else
      chk("attr87_bg", 32'(obs[0]), 32'h555555);
      chk("attr87_fg", 32'(obs[3]), 32'hAAAAAA);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
